ckong_dl_ctrl: RTL and testbench
================================

# ckong_dl_ctrl

ROM download sequencer for the Crazy Kong core. Sits between the HPS `ioctl_*` download bus and the core's ROM/PROM write ports. It decodes each byte into its ROM region and holds the core in reset during loading. It checks the image length and releases reset only after a complete image plus a settle delay. It also sequences user resets through the same hold path, so the core never runs on a partial image.

## Interface
Parameters:
- `CPU_END` = 17'h06000 — first address past CPU program ROM (region 0 = 0 .. CPU_END-1)
- `GFX_END` = 17'h0A000 — first address past tile/sprite ROM (region 1 = CPU_END .. GFX_END-1)
- `PROM_END` = 17'h0A040 — first address past colour PROM (region 2 = GFX_END .. PROM_END-1); also the required image length
- `HOLD_CYCLES` = 256 — reset-release settle delay in clk_sys cycles (≥2)

Ports:
- `clk_sys`  in  1  system clock; sole clock
- `reset`  in  1  synchronous, active-high
- `user_reset`  in  1  menu/button reset request (level)
- `ioctl_download`  in  1  download window active
- `ioctl_wr`  in  1  byte strobe, one cycle per byte
- `ioctl_addr`  in  25  byte address within image
- `ioctl_dout`  in  8  byte data
- `rom_addr`  out  17  region-local address (ioctl_addr − region base)
- `rom_data`  out  8  registered ioctl_dout
- `cpu_rom_we`  out  1  write pulse, region 0
- `gfx_rom_we`  out  1  write pulse, region 1
- `prom_we`  out  1  write pulse, region 2
- `core_reset`  out  1  reset to ckong core
- `dl_done`  out  1  valid image loaded, core running
- `dl_error`  out  1  last download ended with wrong byte count

## Operation
- States: IDLE, LOAD, CHECK, HOLD, RUN.
- Reset: state=IDLE; core_reset=1; all we=0; rom_addr=0; rom_data=0; dl_done=0; dl_error=0; byte_cnt=0.
- IDLE: core_reset=1. Rising edge of ioctl_download → LOAD.
- Any state: rising edge of ioctl_download → LOAD. The transition clears byte_cnt and dl_error, drops dl_done, and asserts core_reset in the next cycle.
- LOAD: each ioctl_wr with ioctl_download=1 is decoded.
  - addr < CPU_END → cpu_rom_we.
  - addr < GFX_END → gfx_rom_we.
  - addr < PROM_END → prom_we.
  - addr ≥ PROM_END (or ioctl_addr[24:17]≠0) → dropped, no pulse, but still counted.
  - byte_cnt: 18 bits, increments per accepted strobe, saturates at 18'h3FFFF.
  - Falling edge of ioctl_download → CHECK.
- CHECK (1 cycle): byte_cnt == PROM_END → HOLD; else dl_error=1 → IDLE.
- HOLD: core_reset=1; counter loads HOLD_CYCLES−1 on entry and decrements. At 0 → RUN.
- RUN: core_reset=0, dl_done=1. user_reset=1 → HOLD with counter reloaded; dl_done stays 1. user_reset held high keeps reloading, so release occurs HOLD_CYCLES after it drops.
- ioctl_wr outside LOAD or with ioctl_download=0 is ignored.
- Write pulses are one-hot or all zero, never more than one high.

## Timing
- Write latency: ioctl_wr at cycle n → rom_addr/rom_data/we valid at cycle n+1. The we pulse is 1 cycle wide. rom_addr/rom_data hold their value until the next accepted write.
- Back-to-back strobes (every cycle) are supported at full rate.
- A strobe in the same cycle as the ioctl_download rise is accepted; the edge and the write are both processed.
- Core release: ioctl_download falls at cycle n → CHECK at n+1 → HOLD n+2 .. n+1+HOLD_CYCLES → core_reset=0 at n+2+HOLD_CYCLES.
- core_reset is registered and glitch-free. It rises within 1 cycle of a download start or reset.
- reset mid-LOAD: all outputs return to reset values next cycle; any partial write pulse is killed.

## Test plan
- Full image: 0xA040 strobes, addr 0..0xA03F, data=addr[7:0]. Required:
  - cpu_rom_we ×0x6000, gfx_rom_we ×0x4000, prom_we ×0x40.
  - Byte 0x6000 appears as gfx rom_addr 0; byte 0xA000 appears as prom rom_addr 0.
  - core_reset falls exactly HOLD_CYCLES+2 cycles after ioctl_download falls; dl_done=1.
- Short image: 0x9000 bytes → dl_error=1, state IDLE, core_reset stays 1, dl_done=0.
- Oversize image: 0xA050 bytes → last 16 bytes produce no we pulse; byte_cnt=0xA050 ≠ PROM_END → dl_error=1.
- Re-download while RUN: core_reset=1 the cycle after the ioctl_download rise; dl_done=0. A valid second image releases again.
- user_reset pulse of 3 cycles in RUN → core_reset=1 for HOLD_CYCLES+3 cycles total; dl_done remains 1; no we pulses.
- reset asserted mid-LOAD after 100 bytes → all outputs at reset values next cycle; a subsequent full image loads cleanly.

Source files
------------

// File: rtl/ckong_dl_ctrl.sv
// ckong_dl_ctrl: ROM download sequencer for the Crazy Kong core.
//   Decodes ioctl download bytes into CPU / GFX / colour-PROM write ports,
//   checks the image length and keeps the core in reset until a complete
//   image has been loaded and a settle delay has elapsed. User resets use
//   the same hold path.
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   user_reset              menu/button reset request (level)
//   ioctl_download/wr/addr/dout  HPS download bus
//   rom_addr, rom_data      region-local address and data of the last write
//   cpu_rom_we, gfx_rom_we, prom_we  one-cycle write pulses per region
//   core_reset              reset to the core
//   dl_done, dl_error       image loaded / last download had a wrong length
module ckong_dl_ctrl #(
   parameter logic [16:0] CPU_END     = 17'h06000,
   parameter logic [16:0] GFX_END     = 17'h0A000,
   parameter logic [16:0] PROM_END    = 17'h0A040,
   parameter int unsigned HOLD_CYCLES = 256
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        user_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [16:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        cpu_rom_we,
   output logic        gfx_rom_we,
   output logic        prom_we,
   output logic        core_reset,
   output logic        dl_done,
   output logic        dl_error
);
   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, HOLD, RUN} state_t;
   state_t state;
   logic dl_prev;
   logic [17:0] byte_cnt;
   logic [CW-1:0] hold_cnt;
   logic dl_rise, accept, hi, in_cpu, in_gfx, in_prom;
   logic [16:0] lo;
   assign dl_rise = ioctl_download & ~dl_prev;
   // a strobe coinciding with the download rise belongs to the new image
   assign accept  = ioctl_wr & ioctl_download & ((state == LOAD) | dl_rise);
   assign hi      = |ioctl_addr[24:17];
   assign lo      = ioctl_addr[16:0];
   assign in_cpu  = ~hi & (lo < CPU_END);
   assign in_gfx  = ~hi & (lo >= CPU_END) & (lo < GFX_END);
   assign in_prom = ~hi & (lo >= GFX_END) & (lo < PROM_END);
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         dl_prev    <= 1'b0;
         byte_cnt   <= '0;
         hold_cnt   <= '0;
         rom_addr   <= '0;
         rom_data   <= '0;
         cpu_rom_we <= 1'b0;
         gfx_rom_we <= 1'b0;
         prom_we    <= 1'b0;
         core_reset <= 1'b1;
         dl_done    <= 1'b0;
         dl_error   <= 1'b0;
      end else begin
         dl_prev    <= ioctl_download;
         cpu_rom_we <= accept & in_cpu;
         gfx_rom_we <= accept & in_gfx;
         prom_we    <= accept & in_prom;
         if (accept & (in_cpu | in_gfx | in_prom)) begin
            rom_addr <= in_cpu ? lo : in_gfx ? lo - CPU_END : lo - GFX_END;
            rom_data <= ioctl_dout;
         end
         if (dl_rise) begin
            state      <= LOAD;
            byte_cnt   <= {17'd0, accept};
            dl_error   <= 1'b0;
            dl_done    <= 1'b0;
            core_reset <= 1'b1;
         end else begin
            case (state)
               IDLE: core_reset <= 1'b1;
               LOAD: begin
                  if (accept && byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                  if (!ioctl_download) state <= CHECK;
               end
               CHECK: begin
                  if (byte_cnt == {1'b0, PROM_END}) begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_LD;
                  end else begin
                     state    <= IDLE;
                     dl_error <= 1'b1;
                  end
               end
               HOLD: begin
                  // a held user reset keeps restarting the settle delay
                  if (user_reset) hold_cnt <= HOLD_LD;
                  else if (hold_cnt == '0) begin
                     state      <= RUN;
                     core_reset <= 1'b0;
                     dl_done    <= 1'b1;
                  end else hold_cnt <= hold_cnt - 1'b1;
               end
               RUN: begin
                  if (user_reset) begin
                     state      <= HOLD;
                     hold_cnt   <= HOLD_LD;
                     core_reset <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ckong_dl_ctrl.sv
// tb_ckong_dl_ctrl: randomized self-checking bench for ckong_dl_ctrl (scaled memory map)
module tb_ckong_dl_ctrl;
   localparam logic [16:0] C = 17'h00600;
   localparam logic [16:0] G = 17'h00A00;
   localparam logic [16:0] P = 17'h00A40;
   localparam int H = 20;
   logic clk_sys = 1'b0, reset = 1'b1, user_reset = 1'b0;
   logic ioctl_download = 1'b0, ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0] ioctl_dout = '0;
   logic [16:0] rom_addr;
   logic [7:0] rom_data;
   logic cpu_rom_we, gfx_rom_we, prom_we, core_reset, dl_done, dl_error;
   int checks = 0, errors = 0;
   int exp_addr = 0, exp_data = 0;
   int cnt_cpu, cnt_gfx, cnt_prom;
   ckong_dl_ctrl #(.CPU_END(C), .GFX_END(G), .PROM_END(P), .HOLD_CYCLES(H)) dut (
      .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .cpu_rom_we(cpu_rom_we), .gfx_rom_we(gfx_rom_we), .prom_we(prom_we),
      .core_reset(core_reset), .dl_done(dl_done), .dl_error(dl_error));
   always #5 clk_sys = ~clk_sys;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask
   function automatic int region(input int a);
      return a < int'(C) ? 0 : a < int'(G) ? 1 : a < int'(P) ? 2 : 3;
   endfunction
   function automatic int base(input int r);
      return r == 0 ? 0 : r == 1 ? int'(C) : int'(G);
   endfunction
   task automatic stream(input int n);
      bit first = 1'b1;
      cnt_cpu = 0; cnt_gfx = 0; cnt_prom = 0;
      ioctl_download = 1'b1;
      for (int i = 0; i < n;) begin
         bit gap = (i > 0) && ($urandom_range(3) == 0);
         int r = gap ? 3 : region(i);
         ioctl_wr = !gap;
         if (!gap) begin
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom);
         end
         tick();
         if (first) begin
            chk("start_core_reset", core_reset, 1);
            chk("start_dl_done", dl_done, 0);
            chk("start_dl_error", dl_error, 0);
            first = 1'b0;
         end
         if (r < 3) begin
            exp_addr = i - base(r);
            exp_data = ioctl_dout;
         end
         chk("we", {cpu_rom_we, gfx_rom_we, prom_we},
             r == 0 ? 3'b100 : r == 1 ? 3'b010 : r == 2 ? 3'b001 : 3'b000);
         chk("rom_addr", rom_addr, exp_addr);
         chk("rom_data", rom_data, exp_data);
         if (!gap && (i == int'(C) || i == int'(G))) chk("region_first_addr", rom_addr, 0);
         cnt_cpu += cpu_rom_we; cnt_gfx += gfx_rom_we; cnt_prom += prom_we;
         if (!gap) i++;
      end
      ioctl_wr = 1'b0;
   endtask
   task automatic finish_load(input bit ok);
      int n = 0;
      ioctl_download = 1'b0;
      chk("cnt_cpu", cnt_cpu, C);
      chk("cnt_gfx", cnt_gfx, G - C);
      chk("cnt_prom", cnt_prom, P - G);
      if (ok) begin
         do begin
            tick();
            n++;
         end while (core_reset !== 1'b0 && n <= H + 10);
         chk("release_latency", n, H + 2);
         chk("done_after_load", dl_done, 1);
         chk("error_after_load", dl_error, 0);
      end else begin
         repeat (H + 5) tick();
         chk("error_flag", dl_error, 1);
         chk("error_core_reset", core_reset, 1);
         chk("error_dl_done", dl_done, 0);
      end
   endtask
   task automatic chk_reset_vals();
      chk("rst_core_reset", core_reset, 1);
      chk("rst_we", {cpu_rom_we, gfx_rom_we, prom_we}, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rom_data", rom_data, 0);
      chk("rst_dl_done", dl_done, 0);
      chk("rst_dl_error", dl_error, 0);
   endtask
   initial begin
      repeat (3) tick();
      chk_reset_vals();
      reset = 1'b0;
      repeat (2) tick();
      chk("idle_core_reset", core_reset, 1);
      stream(int'(P));
      finish_load(1'b1);
      begin
         int n = 0;
         user_reset = 1'b1;
         do begin
            tick();
            n++;
            if (n == 3) user_reset = 1'b0;
            chk("ureset_we", {cpu_rom_we, gfx_rom_we, prom_we}, 0);
            chk("ureset_dl_done", dl_done, 1);
         end while (core_reset !== 1'b0 && n <= H + 10);
         chk("ureset_release", n, H + 3);
      end
      stream(int'(P));
      finish_load(1'b1);
      stream(int'(G) - 17'h100);
      cnt_gfx = int'(G - C); cnt_prom = int'(P - G);
      finish_load(1'b0);
      stream(int'(P) + 16);
      finish_load(1'b0);
      stream(100);
      reset = 1'b1;
      ioctl_wr = 1'b1;
      ioctl_addr = 25'd100;
      tick();
      chk_reset_vals();
      reset = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      exp_addr = 0; exp_data = 0;
      repeat (4) tick();
      chk("post_reset_core_reset", core_reset, 1);
      stream(int'(P));
      finish_load(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
